// File: rtl/bi_shift_serializer_pkg.sv
// Shared types and helpers for the bidirectional shift serializer/receiver pair.
// PARITY_SER_EN appends an even-parity bit to every frame.
package bi_shift_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} ser_state_t;

  localparam logic MODE_LEFT  = 1'b0;
  localparam logic MODE_RIGHT = 1'b1;

  function automatic int frame_len(input int n);
`ifdef PARITY_SER_EN
    return n + 1;
`else
    return n;
`endif
  endfunction

endpackage

// File: rtl/bi_shift_serializer_if.sv
// Word-in / bit-out bundle between the upstream word source and the serializer.
interface bi_shift_serializer_if #(parameter int N = 4);

  logic [N-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         mode;
  logic         dout;
  logic         dout_valid;
  logic         dout_last;
  logic         mode_out;
  logic         busy;

  modport master (
    output din, din_valid, mode,
    input  din_ready, dout, dout_valid, dout_last, mode_out, busy
  );

  modport slave (
    input  din, din_valid, mode,
    output din_ready, dout, dout_valid, dout_last, mode_out, busy
  );

endinterface

// File: rtl/bi_shift_serializer_shift_bit_counter.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
module shift_bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bi_shift_serializer.sv
// Parallel-to-serial transmitter, LSB- or MSB-first per word, registered serial output.
// PARITY_SER_EN: adds a trailing even-parity bit (frame length N+1).
module bi_shift_serializer
  import bi_shift_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst,
  bi_shift_serializer_if.slave bus
);

  localparam int            LEN      = frame_len(N);
  localparam int            CW       = $clog2(N + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(LEN - 1);

  ser_state_t     r_state;
  ser_state_t     w_next;
  logic [LEN-1:0] r_sreg;
  logic [LEN-1:0] w_load;
  logic           r_mode;
  logic           r_dout;
  logic           w_zero;
  logic           w_last;
  logic           w_ready;
  logic           w_accept;

  // Parity rides in the shift register so it falls out after the data bits in either direction
`ifdef PARITY_SER_EN
  assign w_load = (bus.mode == MODE_RIGHT) ? {^bus.din, bus.din} : {bus.din, ^bus.din};
`else
  assign w_load = bus.din;
`endif

  always_comb begin
    w_last   = (r_state == SHIFT) && w_zero;
    w_ready  = (r_state == IDLE) || w_last;
    w_accept = bus.din_valid && w_ready;
    w_next   = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SHIFT;
      SHIFT:   if (w_last && !w_accept) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg <= '0;
      r_dout <= 1'b0;
      r_mode <= MODE_LEFT;
    end else if (w_accept) begin
      r_sreg <= w_load;
      r_mode <= bus.mode;
      r_dout <= (bus.mode == MODE_RIGHT) ? w_load[0] : w_load[LEN-1];
    end else if (r_state == SHIFT) begin
      if (w_last) begin
        r_dout <= 1'b0;
      end else if (r_mode == MODE_RIGHT) begin
        r_sreg <= r_sreg >> 1;
        r_dout <= r_sreg[1];
      end else begin
        r_sreg <= r_sreg << 1;
        r_dout <= r_sreg[LEN-2];
      end
    end
  end

  shift_bit_counter #(.W(CW)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept),
    .i_load_val(LOAD_VAL),
    .i_dec     ((r_state == SHIFT) && !w_accept),
    .o_zero    (w_zero)
  );

  assign bus.din_ready  = w_ready;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = (r_state == SHIFT);
  assign bus.dout_last  = w_last;
  assign bus.mode_out   = r_mode;
  assign bus.busy       = (r_state == SHIFT);

endmodule

// File: tb/tb_bi_shift_serializer.sv
// Directed bench for bi_shift_serializer (N=4); define PARITY_SER_EN to exercise the parity frame.
module tb_bi_shift_serializer;

  localparam int N = 4;
`ifdef PARITY_SER_EN
  localparam int LEN = 5;
`else
  localparam int LEN = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  bi_shift_serializer_if #(.N(N)) bus ();

  bi_shift_serializer #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag, input logic m);
    chk({tag, ".dout"},      8'(bus.dout),       8'd0);
    chk({tag, ".valid"},     8'(bus.dout_valid), 8'd0);
    chk({tag, ".last"},      8'(bus.dout_last),  8'd0);
    chk({tag, ".busy"},      8'(bus.busy),       8'd0);
    chk({tag, ".ready"},     8'(bus.din_ready),  8'd1);
    chk({tag, ".mode_out"},  8'(bus.mode_out),   8'(m));
  endtask

  // ebits[i] is the i-th bit expected on the line
  task automatic run_frame(input string tag, input logic [7:0] ebits, input logic m,
                           input logic hold, input logic [N-1:0] nw, input logic nm);
    for (int i = 0; i < LEN; i++) begin
      @(posedge clk); #1;
      chk($sformatf("%s.dout%0d", tag, i),  8'(bus.dout),       8'(ebits[i]));
      chk($sformatf("%s.valid%0d", tag, i), 8'(bus.dout_valid), 8'd1);
      chk($sformatf("%s.last%0d", tag, i),  8'(bus.dout_last),  8'(i == LEN - 1));
      chk($sformatf("%s.ready%0d", tag, i), 8'(bus.din_ready),  8'(i == LEN - 1));
      chk($sformatf("%s.mode%0d", tag, i),  8'(bus.mode_out),   8'(m));
      chk($sformatf("%s.busy%0d", tag, i),  8'(bus.busy),       8'd1);
      if (!hold) begin
        bus.din_valid = 1'b0;
      end else if (i == LEN - 1) begin
        bus.din  = nw;
        bus.mode = nm;
      end
    end
  endtask

  initial begin
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.mode      = 1'b0;

    #2 rst = 1'b1;
    #1;
    chk_idle("reset_async", 1'b0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk_idle("post_reset", 1'b0);
    end

    bus.din = 4'b1010; bus.mode = 1'b1; bus.din_valid = 1'b1;
    run_frame("lsb", 8'b0000_1010, 1'b1, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    chk_idle("lsb_idle", 1'b1);

    bus.din = 4'b1001; bus.mode = 1'b0; bus.din_valid = 1'b1;
    run_frame("msb", 8'b0000_1001, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    chk_idle("msb_idle", 1'b0);

    bus.din = 4'b0011; bus.mode = 1'b1; bus.din_valid = 1'b1;
    run_frame("b2b_a", 8'b0000_0011, 1'b1, 1'b1, 4'b1100, 1'b0);
    run_frame("b2b_b", 8'b0000_0011, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    chk_idle("b2b_idle", 1'b0);

    bus.din = 4'b1111; bus.mode = 1'b1; bus.din_valid = 1'b1;
    @(posedge clk); #1;
    chk("abort.bit0", 8'(bus.dout), 8'd1);
    bus.din_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort.bit1", 8'(bus.dout), 8'd1);
    chk("abort.mode1", 8'(bus.mode_out), 8'd1);
    #2 rst = 1'b1;
    #1;
    chk_idle("abort_async", 1'b0);
    @(negedge clk) rst = 1'b0;

    bus.din = 4'b0001; bus.mode = 1'b1; bus.din_valid = 1'b1;
`ifdef PARITY_SER_EN
    run_frame("after_abort", 8'b0001_0001, 1'b1, 1'b0, '0, 1'b0);
`else
    run_frame("after_abort", 8'b0000_0001, 1'b1, 1'b0, '0, 1'b0);
`endif
    @(posedge clk); #1;
    chk_idle("after_abort_idle", 1'b1);

`ifdef PARITY_SER_EN
    bus.din = 4'b0111; bus.mode = 1'b1; bus.din_valid = 1'b1;
    run_frame("parity", 8'b0001_0111, 1'b1, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    chk_idle("parity_idle", 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
